// File: rtl/apb_fifo_master_pkg.sv
// Shared definitions for the APB FIFO initiator and its responder twin:
// state encoding, command/response field positions, register map.
package apb_fifo_master_pkg;

   typedef enum logic [3:0] {
      IDLE   = 4'b0001,
      SETUP  = 4'b0010,
      ACCESS = 4'b0100,
      RESP   = 4'b1000
   } state_t;

   localparam int CMD_WR_BIT   = 48;
   localparam int CMD_ADDR_MSB = 47;
   localparam int CMD_ADDR_LSB = 32;
   localparam int CMD_DATA_MSB = 31;
   localparam int CMD_DATA_LSB = 0;

   localparam int RSP_TO_BIT  = 33;
   localparam int RSP_ERR_BIT = 32;

   localparam logic [15:0] REG_CONFIG  = 16'd1;
   localparam logic [15:0] REG_DATA    = 16'd2;
   localparam logic [15:0] REG_STATUS  = 16'd3;
   localparam logic [15:0] REG_CHANNEL = 16'd4;

   function automatic logic need_rsp(input logic wr, input logic rsp_on_wr);
      return !wr || rsp_on_wr;
   endfunction

endpackage

// File: rtl/apb_fifo_master_timer.sv
// ACCESS-phase wait counter; expired marks the last cycle pready may arrive.
module apb_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic pclk,
   input  logic preset_n,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   logic [7:0] wait_cnt;

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         wait_cnt <= 8'd0;
      end else if (clear) begin
         wait_cnt <= 8'd0;
      end else if (tick && !expired) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   assign expired = (wait_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/apb_fifo_master.sv
// APB3 initiator: pops FWFT command words, runs one transfer each,
// and pushes response words (rdata + error flags) to a response FIFO.
module apb_fifo_master
   import apb_fifo_master_pkg::*;
#(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 32,
   parameter int TIMEOUT      = 16,
   parameter int RSP_ON_WRITE = 0
) (
   input  logic                     pclk,
   input  logic                     preset_n,
   output logic [ADDR_W-1:0]        paddr,
   output logic                     psel,
   output logic                     penable,
   output logic                     pwrite,
   output logic [DATA_W-1:0]        pwdata,
   input  logic                     pready,
   input  logic [DATA_W-1:0]        prdata,
   input  logic                     pslverr,
   input  logic                     cmd_empty,
   input  logic [ADDR_W+DATA_W:0]   cmd_data,
   output logic                     cmd_read_inc,
   input  logic                     rsp_full,
   output logic [DATA_W+1:0]        rsp_write_data,
   output logic                     rsp_write_inc,
   output logic                     busy,
   output logic [7:0]               err_count
);

   state_t            state;
   logic [DATA_W+1:0] rsp_q;
   logic              expired;
   logic              rsp_on_wr;
   logic              cmd_ok;

   assign rsp_on_wr = (RSP_ON_WRITE != 0);
   assign cmd_ok = !cmd_empty &&
      (!rsp_full || !need_rsp(cmd_data[CMD_WR_BIT], rsp_on_wr));

   apb_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .pclk     (pclk),
      .preset_n (preset_n),
      .clear    (state == SETUP),
      .tick     (state == ACCESS && !pready),
      .expired  (expired)
   );

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state          <= IDLE;
         paddr          <= '0;
         psel           <= 1'b0;
         penable        <= 1'b0;
         pwrite         <= 1'b0;
         pwdata         <= '0;
         cmd_read_inc   <= 1'b0;
         rsp_write_data <= '0;
         rsp_write_inc  <= 1'b0;
         rsp_q          <= '0;
         busy           <= 1'b0;
         err_count      <= 8'd0;
      end else begin
         cmd_read_inc  <= 1'b0;
         rsp_write_inc <= 1'b0;
         unique case (1'b1)
            (state == IDLE): begin
               if (cmd_ok) begin
                  paddr        <= cmd_data[CMD_ADDR_MSB:CMD_ADDR_LSB];
                  pwdata       <= cmd_data[CMD_DATA_MSB:CMD_DATA_LSB];
                  pwrite       <= cmd_data[CMD_WR_BIT];
                  psel         <= 1'b1;
                  cmd_read_inc <= 1'b1;
                  busy         <= 1'b1;
                  state        <= SETUP;
               end
            end
            (state == SETUP): begin
               penable <= 1'b1;
               state   <= ACCESS;
            end
            (state == ACCESS): begin
               if (pready || expired) begin
                  psel    <= 1'b0;
                  penable <= 1'b0;
                  paddr   <= '0;
                  pwdata  <= '0;
                  pwrite  <= 1'b0;
               end
               if (pready) begin
                  rsp_q <= {1'b0, pslverr,
                            pwrite ? {DATA_W{1'b0}} : prdata};
                  if (need_rsp(pwrite, rsp_on_wr)) begin
                     state <= RESP;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     if (pslverr && err_count != 8'hFF)
                        err_count <= err_count + 8'd1;
                  end
               end else if (expired) begin
                  // aborts always report, even for silent writes
                  rsp_q <= {2'b10, {DATA_W{1'b0}}};
                  state <= RESP;
               end
            end
            (state == RESP): begin
               if (!rsp_full) begin
                  rsp_write_data <= rsp_q;
                  rsp_write_inc  <= 1'b1;
                  busy           <= 1'b0;
                  state          <= IDLE;
                  if ((rsp_q[RSP_TO_BIT] || rsp_q[RSP_ERR_BIT]) &&
                      err_count != 8'hFF)
                     err_count <= err_count + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_fifo_master.sv
// Self-checking bench: FIFO/responder model plus per-cycle protocol checks.
`timescale 1ns/1ps
module tb_apb_fifo_master;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          pclk = 1'b0;
   logic          preset_n = 1'b0;
   logic [AW-1:0] paddr;
   logic          psel, penable, pwrite;
   logic [DW-1:0] pwdata;
   logic          pready, pslverr;
   logic [DW-1:0] prdata;
   logic          cmd_empty;
   logic [48:0]   cmd_data;
   logic          cmd_read_inc;
   logic          rsp_full;
   logic [33:0]   rsp_write_data;
   logic          rsp_write_inc;
   logic          busy;
   logic [7:0]    err_count;

   apb_fifo_master #(
      .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .RSP_ON_WRITE(0)
   ) dut (
      .pclk(pclk), .preset_n(preset_n),
      .paddr(paddr), .psel(psel), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata),
      .pready(pready), .prdata(prdata), .pslverr(pslverr),
      .cmd_empty(cmd_empty), .cmd_data(cmd_data),
      .cmd_read_inc(cmd_read_inc),
      .rsp_full(rsp_full), .rsp_write_data(rsp_write_data),
      .rsp_write_inc(rsp_write_inc),
      .busy(busy), .err_count(err_count)
   );

   always #5 pclk = ~pclk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   logic [48:0] cmd_q[$];
   logic [33:0] exp_rsp[$];
   logic [48:0] cur;
   logic [33:0] e;
   logic [31:0] rd_val;
   logic        err_val;
   int          acc_n, nwait, r;
   bit          end_expect, pend_err;
   int          model_err;
   bit          dir_on, rand_full, full_req;
   int          dir_nwait;
   logic [31:0] dir_rdata;
   logic        dir_err;
   int          cnt_busy, cnt_pop, cnt_push, cnt_pen, cnt_psel;
   logic [33:0] last_rsp;
   logic [15:0] last_addr;
   logic [31:0] last_wdata;
   logic        last_wr;

   task automatic clr_cnt();
      cnt_busy = 0; cnt_pop = 0; cnt_push = 0;
      cnt_pen = 0; cnt_psel = 0;
   endtask

   task automatic set_dir(input int nw, input logic [31:0] rd,
                          input logic er);
      dir_nwait = nw; dir_rdata = rd; dir_err = er;
   endtask

   task automatic drive_fifos();
      if (!rsp_write_inc)
         rsp_full = rand_full ? ($urandom_range(0, 3) == 0) : full_req;
      cmd_empty = (cmd_q.size() == 0);
      cmd_data = cmd_empty ? 49'h0 : cmd_q[0];
   endtask

   // model of command FIFO, responder and expected responses
   initial begin
      pready = 0; prdata = 0; pslverr = 0;
      rsp_full = 0; cmd_empty = 1; cmd_data = 0;
      forever begin
         @(negedge pclk);
         if (!preset_n) begin
            exp_rsp.delete();
            end_expect = 0; pend_err = 0; model_err = 0; acc_n = 0;
            chk("rst_outputs",
                {psel, penable, pwrite, paddr, pwdata, cmd_read_inc,
                 rsp_write_inc, busy, err_count}, 0);
            chk("rst_rsp_data", rsp_write_data, 0);
            pready = 0;
         end else begin
            if (busy) cnt_busy++;
            if (cmd_read_inc) cnt_pop++;
            if (penable) cnt_pen++;
            if (psel) cnt_psel++;
            if (psel && penable) begin
               last_addr = paddr; last_wdata = pwdata; last_wr = pwrite;
            end
            if (pend_err) begin
               if (model_err < 255) model_err++;
               pend_err = 0;
            end
            if (rsp_write_inc) begin
               cnt_push++;
               last_rsp = rsp_write_data;
               chk("rsp_when_full", rsp_full, 0);
               if (exp_rsp.size() == 0) begin
                  chk("rsp_unexpected", rsp_write_inc, 0);
               end else begin
                  e = exp_rsp.pop_front();
                  chk("rsp_word", rsp_write_data, e);
                  if ((e[33] || e[32]) && model_err < 255) model_err++;
               end
            end
            chk("err_count", err_count, model_err);
            chk("pop_is_setup", cmd_read_inc, psel && !penable);
            if (end_expect) begin
               chk("apb_release", psel, 0);
               end_expect = 0;
            end
            if (!psel)
               chk("idle_bus", {penable, pwrite, paddr, pwdata}, 0);
            chk("busy", busy, psel || exp_rsp.size() != 0);
            if (psel && !penable) begin
               chk("pop_allowed",
                   !cmd_empty && !(rsp_full && !cmd_data[48]), 1);
               if (cmd_q.size() != 0) cur = cmd_q.pop_front();
               acc_n = 0;
               if (dir_on) begin
                  nwait = dir_nwait; rd_val = dir_rdata; err_val = dir_err;
               end else begin
                  r = $urandom_range(0, 9);
                  nwait = (r < 8) ? $urandom_range(0, 2) :
                          (r == 8) ? TO - 1 : 50;
                  rd_val = $urandom;
                  err_val = 1'($urandom_range(0, 1));
               end
            end
            if (psel)
               chk("apb_fields", {pwrite, paddr, pwdata},
                   {cur[48], cur[47:32], cur[31:0]});
            pready = 0;
            if (psel && penable) begin
               acc_n++;
               if (acc_n > nwait) begin
                  pready = 1;
                  pslverr = err_val;
                  prdata = cur[48] ? $urandom : rd_val;
                  if (!cur[48])
                     exp_rsp.push_back({1'b0, err_val, rd_val});
                  else if (err_val)
                     pend_err = 1;
                  end_expect = 1;
               end else if (acc_n == TO) begin
                  exp_rsp.push_back({2'b10, 32'h0});
                  end_expect = 1;
               end
            end
         end
         drive_fifos();
      end
   end

   task automatic drain(input string name, input int max);
      int n = 0;
      do begin
         @(negedge pclk); #1;
         n++;
      end while (n < max && !(cmd_q.size() == 0 && !busy &&
                              !rsp_write_inc && !psel));
      chk(name, n < max, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      dir_on = 1; rand_full = 0; full_req = 0;
      set_dir(0, 32'h0, 1'b0);
      clr_cnt();
      repeat (3) @(negedge pclk);
      #2 preset_n = 1;

      // write, ready on first ACCESS cycle, no response
      clr_cnt();
      cmd_q.push_back({1'b1, 16'h0001, 32'h0000_00A5});
      drain("t1_drain", 40);
      chk("t1_pops", cnt_pop, 1);
      chk("t1_push", cnt_push, 0);
      chk("t1_busy", cnt_busy, 2);
      chk("t1_pen", cnt_pen, 1);
      chk("t1_bus", {last_wr, last_addr, last_wdata},
          {1'b1, 16'h0001, 32'h0000_00A5});

      // read with 2 wait states
      clr_cnt();
      set_dir(2, 32'h0000_0300, 1'b0);
      cmd_q.push_back({1'b0, 16'h0003, 32'h0});
      drain("t2_drain", 40);
      chk("t2_pen", cnt_pen, 3);
      chk("t2_push", cnt_push, 1);
      chk("t2_rsp", last_rsp, 34'h0_0000_0300);
      chk("t2_busy", cnt_busy, 5);

      // read with slave error
      clr_cnt();
      set_dir(0, 32'hDEAD_BEEF, 1'b1);
      cmd_q.push_back({1'b0, 16'h0002, 32'h0});
      drain("t3_drain", 40);
      chk("t3_rsp", last_rsp, {2'b01, 32'hDEAD_BEEF});
      chk("t3_err", err_count, 8'd1);

      // timeout after TO ACCESS cycles
      clr_cnt();
      set_dir(50, 32'h1234_5678, 1'b0);
      cmd_q.push_back({1'b0, 16'h0004, 32'h0});
      drain("t4_drain", 40);
      chk("t4_pen", cnt_pen, TO);
      chk("t4_rsp", last_rsp, 34'h2_0000_0000);
      chk("t4_err", err_count, 8'd2);

      // response FIFO full blocks a read
      set_dir(0, 32'h0000_0042, 1'b0);
      full_req = 1;
      @(negedge pclk); #1;
      clr_cnt();
      cmd_q.push_back({1'b0, 16'h0001, 32'h0});
      repeat (5) @(negedge pclk);
      #1;
      chk("t5_nopop", cnt_pop, 0);
      chk("t5_nopsel", cnt_psel, 0);
      full_req = 0;
      @(negedge pclk);
      @(negedge pclk); #1;
      chk("t5_start", {psel, penable, cmd_read_inc}, 3'b101);
      drain("t5_drain", 40);
      chk("t5_rsp", last_rsp, 34'h0_0000_0042);

      // reset in the middle of ACCESS
      set_dir(50, 32'h0, 1'b0);
      cmd_q.push_back({1'b0, 16'h0001, 32'h0});
      cmd_q.push_back({1'b1, 16'h0002, 32'h0000_0077});
      begin
         int n = 0;
         while (!(psel && penable) && n < 20) begin
            @(negedge pclk); #1;
            n++;
         end
         chk("t6_reach_access", psel && penable, 1);
      end
      @(posedge pclk); #3;
      preset_n = 0;
      #1;
      chk("t6_async", {psel, penable, busy}, 3'b000);
      set_dir(0, 32'h0, 1'b0);
      clr_cnt();
      @(negedge pclk);
      @(negedge pclk); #2;
      preset_n = 1;
      drain("t6_drain", 40);
      chk("t6_push", cnt_push, 0);
      chk("t6_pops", cnt_pop, 1);
      chk("t6_bus", {last_wr, last_addr, last_wdata},
          {1'b1, 16'h0002, 32'h0000_0077});

      // randomized traffic against the model
      dir_on = 0;
      rand_full = 1;
      for (int i = 0; i < 600; ) begin
         @(posedge pclk); #2;
         if (cmd_q.size() < 3 && $urandom_range(0, 3) != 0) begin
            logic [48:0] c;
            c[48] = 1'($urandom_range(0, 1));
            c[47:32] = ($urandom_range(0, 1) == 0) ?
                       16'($urandom_range(1, 4)) : 16'($urandom);
            c[31:0] = $urandom;
            cmd_q.push_back(c);
            i++;
         end
      end
      rand_full = 0;
      drain("rand_drain", 400);
      chk("err_saturated", err_count, 8'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apb_fifo_master.md
Name: apb_fifo_master

Overview:
APB initiator, the requester-side counterpart to the APB-to-FIFO responder. It pops command words from a first-word-fall-through command FIFO and executes each as one APB3 transfer on pclk. For reads, and optionally writes, it pushes a response word (rdata plus error flags) into a response FIFO. Used by test harnesses and the core-side host path to drive the transceiver register map without a CPU.

Parameters:
ADDR_W, 16, APB address width.
DATA_W, 32, APB data width.
TIMEOUT, 16, maximum ACCESS cycles waiting for pready before abort; legal range 1..255.
RSP_ON_WRITE, 0, 1 = write transfers also push a response word.

Ports:
pclk  in  1  APB clock.
preset_n  in  1  asynchronous active-low reset.
paddr  out  ADDR_W  APB address.
psel  out  1  APB select.
penable  out  1  APB enable.
pwrite  out  1  APB direction, 1 = write.
pwdata  out  DATA_W  APB write data.
pready  in  1  APB ready from the responder.
prdata  in  DATA_W  APB read data.
pslverr  in  1  APB error.
cmd_empty  in  1  command FIFO empty.
cmd_data  in  1+ADDR_W+DATA_W  FWFT head of command FIFO: [48] write, [47:32] addr, [31:0] wdata.
cmd_read_inc  out  1  one-cycle pop strobe.
rsp_full  in  1  response FIFO full.
rsp_write_data  out  2+DATA_W  response word: [33] timeout, [32] slverr, [31:0] rdata.
rsp_write_inc  out  1  one-cycle push strobe.
busy  out  1  high whenever state != IDLE.
err_count  out  8  saturating count of slverr or timeout responses.

Behaviour:
- Reset is asynchronous, active-low, on preset_n; clock is pclk. All outputs reset to 0. State resets to IDLE and wait_cnt to 0.
- All outputs are registered. One-hot states: IDLE, SETUP, ACCESS, RESP.
- need_rsp = ~cmd write | RSP_ON_WRITE.
- IDLE:
  - If !cmd_empty and (!rsp_full or !need_rsp): latch cmd_data, pulse cmd_read_inc for exactly 1 cycle, go to SETUP.
  - Otherwise stay in IDLE. psel, penable, paddr, pwdata and pwrite are driven to 0.
- SETUP: psel=1, penable=0, paddr/pwrite/pwdata from the latched command. Lasts exactly 1 cycle, then ACCESS.
- ACCESS: psel=1, penable=1, address, data and direction held stable. wait_cnt clears on entry.
  - pready=1: capture prdata (forced to 0 for writes) and pslverr. Deassert psel/penable at the next edge. Go to RESP if need_rsp, else IDLE.
  - pready=0 and wait_cnt < TIMEOUT-1: increment wait_cnt.
  - pready=0 and wait_cnt == TIMEOUT-1: abort. psel/penable drop at the next edge, response = {1,0,0}, go to RESP (response issued even when need_rsp=0; rsp_full is rechecked in RESP).
  - pready=1 in the final allowed cycle counts as success, not timeout.
- RESP: when !rsp_full, assert rsp_write_inc for 1 cycle with the response word, then go to IDLE. Otherwise hold RESP with rsp_write_inc=0.
- Throughput: 3 cycles per transfer without response, 4 with response.
- err_count increments on each pushed or completed transfer with slverr or timeout, and saturates at 255.
- Reset mid-transfer: psel/penable fall asynchronously and a popped command is discarded. No response is produced.
- Commands are never popped while state != IDLE; at most one transfer is outstanding.

Decomposition:
- Shared package holds:
  - state encoding;
  - command field positions (CMD_WR_BIT=48, CMD_ADDR_MSB/LSB, CMD_DATA_MSB/LSB);
  - response bit positions (RSP_TO_BIT=33, RSP_ERR_BIT=32);
  - register addresses CONFIG=1, DATA=2, STATUS=3, CHANNEL=4, shared with the APB responder.
- One sub-module is natural: apb_wait_timer, holding wait_cnt and the expiry compare.

Test Plan:
- cmd {1,0x0001,0x0000_00A5}, pready=1 on first ACCESS, RSP_ON_WRITE=0 -> SETUP then ACCESS with paddr=1, pwrite=1, pwdata=0xA5; cmd_read_inc 1 pulse; no rsp_write_inc; busy for 2 cycles.
- cmd {0,0x0003,x}, responder inserts 2 wait states then prdata=0x0000_0300 -> penable high for 3 cycles; rsp_write_data=0x0_0000_0300; one push.
- Read with pslverr=1, prdata=0xDEAD_BEEF -> rsp_write_data={0,1,0xDEADBEEF}; err_count 0 -> 1.
- TIMEOUT=4, pready held 0 -> exactly 4 ACCESS cycles, then psel=0; response {1,0,0}; err_count increments.
- Read cmd queued with rsp_full=1 -> no pop and psel stays 0. Release rsp_full -> transfer starts on the next cycle.
- preset_n asserted during ACCESS -> psel/penable/busy go 0 immediately; no response pushed; next queued cmd executes normally after release.
